// File: rtl/aludec_seq.sv
// Registered ALU control decoder with MULT/DIV sequencing.
// All outputs are flops; multi-cycle ops hold busy until a done/ctrl_valid pulse.
module aludec_seq #(
  parameter int CTRL_W  = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic [1:0]        aluop,
  output logic [CTRL_W-1:0] alucontrol,
  output logic              ctrl_valid,
  output logic              busy,
  output logic              done,
  output logic              illegal
);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [4:0] code;
    logic       multi;
    logic       is_div;
    logic       bad;
  } dec_t;

  localparam logic [CNT_W-1:0] MUL_START = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_START = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Unmatched encodings fall through to code 0 with bad set, never X.
  function automatic dec_t decode(input logic [1:0] cls,
                                  input logic [5:0] op_f,
                                  input logic [5:0] funct_f);
    dec_t d;
    d = '0;
    case (cls)
      2'b00: d.code = 5'b00010;
      2'b01: d.code = 5'b10010;
      2'b10: begin
        case (funct_f)
          6'b100000: d.code = 5'b00010;
          6'b100010: d.code = 5'b10010;
          6'b100100: d.code = 5'b00000;
          6'b100101: d.code = 5'b00001;
          6'b101010: d.code = 5'b10011;
          6'b001010: d.code = 5'b00100;
          6'b000100: d.code = 5'b00110;
          6'b110011: d.code = 5'b01001;
          6'b011000: begin
            d.code  = 5'b01010;
            d.multi = 1'b1;
          end
          6'b011010: begin
            d.code   = 5'b01011;
            d.multi  = 1'b1;
            d.is_div = 1'b1;
          end
          default:   d.bad = 1'b1;
        endcase
      end
      default: begin
        case (op_f)
          6'b100101: d.code = 5'b00101;
          6'b011101: d.code = 5'b00111;
          6'b010001: d.code = 5'b01000;
          default:   d.bad  = 1'b1;
        endcase
      end
    endcase
    return d;
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CTRL_W-1:0]   alucontrol_d;
  logic                ctrl_valid_d, busy_d, done_d, illegal_d;
  dec_t                dec;

  always_comb begin
    dec = decode(aluop, op, funct);
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    cnt_d        = cnt_q;
    alucontrol_d = alucontrol;
    ctrl_valid_d = 1'b0;
    busy_d       = busy;
    done_d       = 1'b0;
    illegal_d    = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (valid_in) begin
          alucontrol_d = CTRL_W'(dec.code);
          if (dec.multi) begin
            busy_d  = 1'b1;
            cnt_d   = dec.is_div ? DIV_START : MUL_START;
            state_d = RUN;
          end else begin
            ctrl_valid_d = 1'b1;
            illegal_d    = dec.bad;
          end
        end
      end
      RUN: begin
        // valid_in is ignored here; upstream holds the instruction until done.
        if (cnt_q == CNT_ONE) begin
          state_d      = IDLE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          ctrl_valid_d = 1'b1;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      alucontrol <= '0;
      ctrl_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alucontrol <= alucontrol_d;
      ctrl_valid <= ctrl_valid_d;
      busy       <= busy_d;
      done       <= done_d;
      illegal    <= illegal_d;
    end
  end

endmodule

// File: tb/tb_aludec_seq.sv
// Scoreboard bench for aludec_seq: stimulus pushes expected decodes,
// a negedge monitor pops one per ctrl_valid pulse.
module tb_aludec_seq;

  logic       clk;
  logic       reset;
  logic       valid_in;
  logic [5:0] op;
  logic [5:0] funct;
  logic [1:0] aluop;
  logic [4:0] alucontrol;
  logic       ctrl_valid, busy, done, illegal;

  aludec_seq #(.CTRL_W(5), .MUL_LAT(4), .DIV_LAT(8), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .op         (op),
    .funct      (funct),
    .aluop      (aluop),
    .alucontrol (alucontrol),
    .ctrl_valid (ctrl_valid),
    .busy       (busy),
    .done       (done),
    .illegal    (illegal)
  );

  typedef struct packed {
    logic [4:0] code;
    logic       ill;
    logic       dn;
  } exp_t;

  typedef struct packed {
    logic [1:0] a;
    logic [5:0] o;
    logic [5:0] f;
    logic [4:0] code;
    logic       ill;
  } vec_t;

  exp_t sb[$];
  exp_t got;
  int   vectors     = 0;
  int   miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] a, input logic [5:0] o, input logic [5:0] f);
    valid_in = 1'b1;
    aluop    = a;
    op       = o;
    funct    = f;
  endtask

  task automatic idle();
    valid_in = 1'b0;
  endtask

  task automatic push(input logic [4:0] code, input logic ill, input logic dn);
    exp_t e;
    e.code = code;
    e.ill  = ill;
    e.dn   = dn;
    sb.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alucontrol"}, alucontrol, 0);
    check({tag, "_ctrl_valid"}, ctrl_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_illegal"}, illegal, 0);
  endtask

  // Monitor: every ctrl_valid pulse must match the oldest expected decode.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (ctrl_valid) begin
          if (sb.size() == 0) begin
            check("spurious_ctrl_valid", ctrl_valid, 0);
          end else begin
            got = sb.pop_front();
            check("sb_alucontrol", alucontrol, got.code);
            check("sb_illegal", illegal, got.ill);
            check("sb_done", done, got.dn);
          end
        end else begin
          if (done)    check("done_without_ctrl_valid", done, 0);
          if (illegal) check("illegal_without_ctrl_valid", illegal, 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [13];
    tbl = '{
      '{2'b00, 6'b000000, 6'b000000, 5'b00010, 1'b0},
      '{2'b01, 6'b000000, 6'b000000, 5'b10010, 1'b0},
      '{2'b10, 6'b000000, 6'b100010, 5'b10010, 1'b0},
      '{2'b10, 6'b000000, 6'b100100, 5'b00000, 1'b0},
      '{2'b10, 6'b000000, 6'b111111, 5'b00000, 1'b1},
      '{2'b10, 6'b000000, 6'b100101, 5'b00001, 1'b0},
      '{2'b10, 6'b000000, 6'b001010, 5'b00100, 1'b0},
      '{2'b11, 6'b000000, 6'b100000, 5'b00000, 1'b1},
      '{2'b10, 6'b000000, 6'b000100, 5'b00110, 1'b0},
      '{2'b10, 6'b010001, 6'b000000, 5'b00000, 1'b1},
      '{2'b10, 6'b000000, 6'b110011, 5'b01001, 1'b0},
      '{2'b11, 6'b100101, 6'b000000, 5'b00101, 1'b0},
      '{2'b11, 6'b011101, 6'b000000, 5'b00111, 1'b0}
    };

    reset    = 1'b1;
    valid_in = 1'b0;
    op       = '0;
    funct    = '0;
    aluop    = '0;
    #1;
    check_all_zero("reset");
    step();
    step();
    reset = 1'b0;
    step();
    check_all_zero("post_reset");

    // Back-to-back single-cycle decodes.
    drive(2'b10, 6'b000000, 6'b100000); push(5'b00010, 1'b0, 1'b0);
    step();
    check("b2b_first_valid", ctrl_valid, 1);
    check("b2b_first_busy", busy, 0);
    drive(2'b10, 6'b000000, 6'b101010); push(5'b10011, 1'b0, 1'b0);
    step();
    check("b2b_second_valid", ctrl_valid, 1);
    check("b2b_second_busy", busy, 0);
    idle();

    // LI then an unmatched opcode; illegal is a single-cycle pulse.
    step();
    drive(2'b11, 6'b010001, 6'b000000); push(5'b01000, 1'b0, 1'b0);
    step();
    drive(2'b11, 6'b111111, 6'b000000); push(5'b00000, 1'b1, 1'b0);
    step();
    check("illegal_pulse", illegal, 1);
    idle();
    step();
    check("illegal_clears", illegal, 0);
    check("ctrl_valid_clears", ctrl_valid, 0);

    // Remaining table entries issued every cycle.
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].a, tbl[i].o, tbl[i].f);
      push(tbl[i].code, tbl[i].ill, 1'b0);
      step();
    end
    idle();
    step();
    check("hold_alucontrol", alucontrol, 5'b00111);
    check("hold_ctrl_valid", ctrl_valid, 0);

    // Reset asserted mid-stream clears outputs immediately.
    drive(2'b00, 6'b000000, 6'b000000); push(5'b00010, 1'b0, 1'b0);
    step();
    idle();
    #2 reset = 1'b1;
    #1;
    check_all_zero("midstream_reset");
    @(posedge clk);
    step();
    reset = 1'b0;
    step();
    check_all_zero("after_midstream_release");

    // MULT with an ADD held on valid_in throughout busy.
    drive(2'b10, 6'b000000, 6'b011000); push(5'b01010, 1'b0, 1'b1);
    step();
    check("mul_e0_busy", busy, 1);
    check("mul_e0_alucontrol", alucontrol, 5'b01010);
    check("mul_e0_ctrl_valid", ctrl_valid, 0);
    drive(2'b00, 6'b000000, 6'b000000); push(5'b00010, 1'b0, 1'b0);
    step();
    check("mul_e1_busy", busy, 1);
    step();
    check("mul_e2_busy", busy, 1);
    step();
    check("mul_e3_busy", busy, 0);
    check("mul_e3_done", done, 1);
    check("mul_e3_ctrl_valid", ctrl_valid, 1);
    step();
    check("mul_e4_add_alucontrol", alucontrol, 5'b00010);
    check("mul_e4_ctrl_valid", ctrl_valid, 1);
    check("mul_e4_done", done, 0);
    idle();
    step();
    check("mul_after_ctrl_valid", ctrl_valid, 0);

    // DIV: seven busy cycles, then done.
    drive(2'b10, 6'b000000, 6'b011010); push(5'b01011, 1'b0, 1'b1);
    step();
    idle();
    check("div_e0_busy", busy, 1);
    check("div_e0_alucontrol", alucontrol, 5'b01011);
    for (int i = 1; i < 7; i++) begin
      step();
      check($sformatf("div_e%0d_busy", i), busy, 1);
      check($sformatf("div_e%0d_alucontrol", i), alucontrol, 5'b01011);
    end
    step();
    check("div_e7_done", done, 1);
    check("div_e7_busy", busy, 0);
    check("div_e7_alucontrol", alucontrol, 5'b01011);
    step();
    check("div_done_clears", done, 0);

    // DIV aborted by reset on its third busy cycle; nothing expected from it.
    drive(2'b10, 6'b000000, 6'b011010);
    step();
    idle();
    step();
    step();
    check("div_abort_busy_before", busy, 1);
    #2 reset = 1'b1;
    #1;
    check_all_zero("div_abort_reset");
    @(posedge clk);
    step();
    reset = 1'b0;
    step();
    check("div_abort_no_done_1", done, 0);
    check("div_abort_no_busy", busy, 0);
    step();
    check("div_abort_no_done_2", done, 0);
    drive(2'b00, 6'b000000, 6'b000000); push(5'b00010, 1'b0, 1'b0);
    step();
    idle();
    check("post_abort_add", alucontrol, 5'b00010);
    check("post_abort_done", done, 0);
    check("post_abort_busy", busy, 0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) step();
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aludec_seq.md
Name: aludec_seq

Overview:
- Registered, multi-cycle-aware successor to the single-cycle ALU decoder.
- Decodes op/funct/aluop into a CTRL_W-bit alucontrol word. Adds MULT/DIV multi-cycle ops, sequenced by an FSM with a busy/done handshake to the datapath and hazard logic.
- Undefined encodings give a deterministic zero output and an illegal flag, never X.

Parameters:
- CTRL_W, 5: alucontrol width. Must be >= 5; codes are zero-extended above bit 4.
- MUL_LAT, 4: MULT latency in cycles. Must be >= 2.
- DIV_LAT, 8: DIV latency in cycles. Must be >= 2.
- CNT_W, 4: latency counter width. Must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid_in  in  1  decode request; sampled only when busy==0.
- op  in  6  opcode, used when aluop==11.
- funct  in  6  function field, used when aluop==10.
- aluop  in  2  class from the main decoder.
- alucontrol  out  CTRL_W  registered ALU control word.
- ctrl_valid  out  1  one-cycle pulse: alucontrol holds a newly completed decode/op.
- busy  out  1  multi-cycle op in progress; the pipeline stalls on it.
- done  out  1  one-cycle pulse at multi-cycle completion.
- illegal  out  1  one-cycle pulse: unmatched encoding was accepted.

Behaviour:
- Reset (async, any time, including mid-RUN): state=IDLE, cnt=0, alucontrol=0, ctrl_valid=0, busy=0, done=0, illegal=0.
- Decode table, aluop:
  - 00: ADD 00010
  - 01: SUB 10010
  - 10: by funct, below
  - 11: by op, below
- funct table (aluop==10):
  - 100000 ADD 00010
  - 100010 SUB 10010
  - 100100 AND 00000
  - 100101 OR 00001
  - 101010 SLT 10011
  - 001010 MOVZ 00100
  - 000100 SLLV 00110
  - 110011 MIX4 01001
  - 011000 MULT 01010 (multi-cycle, MUL_LAT)
  - 011010 DIV 01011 (multi-cycle, DIV_LAT)
- op table (aluop==11):
  - 100101 LHU 00101
  - 011101 BLT 00111
  - 010001 LI 01000
- Unmatched funct/op: code 0, illegal=1.
- FSM states: IDLE, RUN.
- IDLE, valid_in=0: alucontrol holds; ctrl_valid/done/illegal go to 0.
- IDLE, valid_in=1, single-cycle code: next edge loads alucontrol and sets ctrl_valid=1 for one cycle. Stays in IDLE, so back-to-back issue every cycle is allowed.
- IDLE, valid_in=1, unmatched: alucontrol=0, ctrl_valid=1, illegal=1 for one cycle.
- IDLE, valid_in=1, MULT/DIV: next edge loads alucontrol, sets busy=1, ctrl_valid=0, cnt=LAT-1, state=RUN.
- RUN, per edge:
  - if cnt==1: state=IDLE, busy=0, done=1, ctrl_valid=1 (one cycle), cnt=0.
  - else: cnt-1.
  - alucontrol holds throughout.
- Timing: issue at edge 0 gives busy high after edges 0..LAT-2 and done/ctrl_valid high after edge LAT-1.
- valid_in while busy==1 is ignored; upstream holds the instruction. The first acceptable edge is the one after done rises.
- No combinational path from inputs to outputs. All outputs are flops.

Test Plan:
- Assert reset mid-stream, release -> all outputs 0 in the same cycle as assertion, and 0 after release until valid_in.
- valid_in, aluop=10, funct=100000, then funct=101010 on the next cycle -> alucontrol 00010 then 10011, ctrl_valid high two consecutive cycles, busy=0.
- aluop=11, op=010001 -> alucontrol 01000. Then op=111111 -> alucontrol 00000, illegal=1 and ctrl_valid=1 for exactly one cycle.
- MULT (funct=011000), MUL_LAT=4, issue at edge 0 -> alucontrol 01010. busy=1 after edges 0,1,2. Edge 3: busy=0, done=1, ctrl_valid=1, then both 0. ADD held on valid_in during busy is ignored until edge 4, then accepted.
- DIV with DIV_LAT=8 -> busy 7 cycles, done after edge 7, alucontrol 01011 stable throughout.
- Assert reset at the 3rd busy cycle of DIV -> busy/alucontrol 0 immediately. After release, a new ADD decodes normally with no residual done pulse.
